// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX path among NUM_REQ byte producers.
// One grant per frame, tracked through the transmitter's busy flag with a start timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ack,
    input  logic                          i_tx_busy,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic                          o_tx_data_valid,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_active,
    output logic                          o_done,
    output logic                          o_timeout
);

    localparam int ID_WIDTH  = $clog2(NUM_REQ);
    localparam int CNT_WIDTH = $clog2(START_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(START_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0]   ACK_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    logic [ID_WIDTH-1:0]    ptr_r;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [ID_WIDTH-1:0]    winner_s;
    logic [DATA_WIDTH-1:0]  req_bytes_s [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_bytes_s[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester strictly after ptr, wrapping; ptr itself is checked last.
    function automatic logic [ID_WIDTH-1:0] pick_winner(
        input logic [NUM_REQ-1:0]  valid,
        input logic [ID_WIDTH-1:0] ptr
    );
        logic [ID_WIDTH-1:0] w;
        logic [ID_WIDTH-1:0] cand;
        logic                found;
        w     = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
            if (!found && valid[cand]) begin
                w     = cand;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Round-robin winner for the current request vector.
    always_comb begin
        winner_s = pick_winner(i_req_valid, ptr_r);
    end

    // Frame sequencing FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r         <= ST_IDLE;
            ptr_r           <= ID_WIDTH'(NUM_REQ - 1);
            cnt_r           <= {CNT_WIDTH{1'b0}};
            o_req_ack       <= {NUM_REQ{1'b0}};
            o_tx_data       <= {DATA_WIDTH{1'b0}};
            o_tx_data_valid <= 1'b0;
            o_grant_id      <= {ID_WIDTH{1'b0}};
            o_active        <= 1'b0;
            o_done          <= 1'b0;
            o_timeout       <= 1'b0;
        end else begin
            o_req_ack       <= {NUM_REQ{1'b0}};
            o_tx_data_valid <= 1'b0;
            o_done          <= 1'b0;
            o_timeout       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if ((|i_req_valid) && !i_tx_busy) begin
                        state_r         <= ST_ISSUE;
                        o_tx_data       <= req_bytes_s[winner_s];
                        o_grant_id      <= winner_s;
                        ptr_r           <= winner_s;
                        cnt_r           <= {CNT_WIDTH{1'b0}};
                        o_tx_data_valid <= 1'b1;
                        o_req_ack       <= ACK_ONE << winner_s;
                        o_active        <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    // busy wins over an expiring counter on the same cycle
                    if (i_tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= ST_IDLE;
                        o_timeout <= 1'b1;
                        o_active  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        state_r  <= ST_IDLE;
                        o_done   <= 1'b1;
                        o_active <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    o_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple TX busy model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_uart_tx_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_ack;
    wire         i_tx_busy;
    logic [7:0]  o_tx_data;
    logic        o_tx_data_valid;
    logic [1:0]  o_grant_id;
    logic        o_active;
    logic        o_done;
    logic        o_timeout;

    logic force_busy;
    logic model_busy;
    logic tx_en;
    int   busy_len;
    int   dly;
    int   len;

    int checks;
    int failures;

    assign i_tx_busy = force_busy | model_busy;

    uart_tx_arbiter #(
        .NUM_REQ      (4),
        .DATA_WIDTH   (8),
        .START_TIMEOUT(8)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .i_req_data     (i_req_data),
        .o_req_ack      (o_req_ack),
        .i_tx_busy      (i_tx_busy),
        .o_tx_data      (o_tx_data),
        .o_tx_data_valid(o_tx_data_valid),
        .o_grant_id     (o_grant_id),
        .o_active       (o_active),
        .o_done         (o_done),
        .o_timeout      (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // TX model: busy rises two cycles after the data-valid pulse and lasts busy_len cycles.
    initial begin
        model_busy = 1'b0;
        dly = 0;
        len = 0;
        forever begin
            @(posedge i_clk);
            #2;
            if (i_rst) begin
                dly = 0;
                len = 0;
            end else if (len > 0) begin
                len = len - 1;
            end else if (dly > 0) begin
                dly = dly - 1;
                if (dly == 0) len = busy_len;
            end else if (tx_en && o_tx_data_valid) begin
                dly = 2;
            end
            model_busy = (len > 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic wait_issue(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_tx_data_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit seen, output int acks, output bit fell_one_before);
        logic prev1;
        logic prev2;
        seen = 1'b0;
        acks = 0;
        fell_one_before = 1'b0;
        prev1 = 1'b0;
        prev2 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_clk);
            if (o_done) begin
                seen = 1'b1;
                fell_one_before = (prev2 == 1'b1) && (prev1 == 1'b0);
                break;
            end
            if (o_req_ack != 4'b0000) acks++;
            prev2 = prev1;
            prev1 = i_tx_busy;
        end
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        bit seen;
        bit fell;
        int acks;
        int tcount;
        int tfirst;
        checks = 0;
        failures = 0;
        i_rst = 1'b1;
        i_req_valid = 4'b0000;
        i_req_data = 32'h0;
        force_busy = 1'b0;
        tx_en = 1'b1;
        busy_len = 10;

        // reset state
        do_reset();
        @(negedge i_clk);
        check_eq("rst_ack", 32'(o_req_ack), 32'h0);
        check_eq("rst_valid", 32'(o_tx_data_valid), 32'h0);
        check_eq("rst_data", 32'(o_tx_data), 32'h0);
        check_eq("rst_grant", 32'(o_grant_id), 32'h0);
        check_eq("rst_active", 32'(o_active), 32'h0);
        check_eq("rst_done", 32'(o_done), 32'h0);
        check_eq("rst_timeout", 32'(o_timeout), 32'h0);

        // single request from requester 2
        i_req_data = 32'h33_A5_11_22;
        i_req_valid = 4'b0100;
        @(negedge i_clk);
        check_eq("single_valid", 32'(o_tx_data_valid), 32'h1);
        check_eq("single_ack", 32'(o_req_ack), 32'h4);
        check_eq("single_data", 32'(o_tx_data), 32'hA5);
        check_eq("single_grant", 32'(o_grant_id), 32'h2);
        check_eq("single_active", 32'(o_active), 32'h1);
        i_req_valid = 4'b0000;
        @(negedge i_clk);
        check_eq("single_valid_pulse", 32'(o_tx_data_valid), 32'h0);
        check_eq("single_ack_pulse", 32'(o_req_ack), 32'h0);
        wait_done(seen, acks, fell);
        check_eq("single_done", 32'(seen), 32'h1);
        check_eq("single_done_timing", 32'(fell), 32'h1);
        check_eq("single_done_inactive", 32'(o_active), 32'h0);
        check_eq("single_hold_data", 32'(o_tx_data), 32'hA5);
        check_eq("single_hold_grant", 32'(o_grant_id), 32'h2);

        // round-robin from reset with all four requesting
        i_req_data = 32'h13_12_11_10;
        i_req_valid = 4'b1111;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            wait_issue(seen);
            check_eq("rr_issue", 32'(seen), 32'h1);
            check_eq("rr_grant", 32'(o_grant_id), 32'(exp_order[f]));
            check_eq("rr_ack", 32'(o_req_ack), 32'h1 << exp_order[f]);
            check_eq("rr_data", 32'(o_tx_data), 32'h10 + 32'(exp_order[f]));
            wait_done(seen, acks, fell);
            check_eq("rr_done", 32'(seen), 32'h1);
            check_eq("rr_no_extra_ack", 32'(acks), 32'h0);
        end
        i_req_valid = 4'b0000;

        // wrap and skip after a grant to requester 3
        i_req_data = 32'hD3_C2_B1_A0;
        do_reset();
        i_req_valid = 4'b1000;
        wait_issue(seen);
        check_eq("wrap_first", 32'(o_grant_id), 32'h3);
        i_req_valid = 4'b0110;
        wait_done(seen, acks, fell);
        check_eq("wrap_done0", 32'(seen), 32'h1);
        wait_issue(seen);
        check_eq("wrap_grant1", 32'(o_grant_id), 32'h1);
        check_eq("wrap_data1", 32'(o_tx_data), 32'hB1);
        wait_done(seen, acks, fell);
        wait_issue(seen);
        check_eq("wrap_grant2", 32'(o_grant_id), 32'h2);
        check_eq("wrap_ack2", 32'(o_req_ack), 32'h4);
        i_req_valid = 4'b0000;
        wait_done(seen, acks, fell);
        check_eq("wrap_done2", 32'(seen), 32'h1);

        // start timeout: transmitter never goes busy
        tx_en = 1'b0;
        i_req_valid = 4'b0001;
        wait_issue(seen);
        check_eq("to_grant", 32'(o_grant_id), 32'h0);
        check_eq("to_ack", 32'(o_req_ack), 32'h1);
        i_req_valid = 4'b0000;
        tcount = 0;
        tfirst = 0;
        acks = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_clk);
            if (o_req_ack != 4'b0000) acks++;
            if (o_timeout) begin
                tcount++;
                if (tfirst == 0) tfirst = i;
            end
        end
        check_eq("to_count", 32'(tcount), 32'h1);
        check_eq("to_window", 32'(tfirst >= 8 && tfirst <= 10), 32'h1);
        check_eq("to_no_second_ack", 32'(acks), 32'h0);
        check_eq("to_idle", 32'(o_active), 32'h0);
        tx_en = 1'b1;
        i_req_valid = 4'b0010;
        wait_issue(seen);
        check_eq("to_next_issue", 32'(seen), 32'h1);
        check_eq("to_next_grant", 32'(o_grant_id), 32'h1);
        i_req_valid = 4'b0000;
        wait_done(seen, acks, fell);
        check_eq("to_next_done", 32'(seen), 32'h1);

        // busy already high when a request arrives
        tx_en = 1'b0;
        force_busy = 1'b1;
        i_req_valid = 4'b0001;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            if (o_req_ack != 4'b0000 || o_tx_data_valid) acks++;
        end
        check_eq("busy_no_grant", 32'(acks), 32'h0);
        force_busy = 1'b0;
        tx_en = 1'b1;
        @(negedge i_clk);
        check_eq("busy_then_valid", 32'(o_tx_data_valid), 32'h1);
        check_eq("busy_then_ack", 32'(o_req_ack), 32'h1);
        i_req_valid = 4'b0000;
        wait_done(seen, acks, fell);
        check_eq("busy_done", 32'(seen), 32'h1);

        // reset in the middle of a frame
        i_req_valid = 4'b0100;
        wait_issue(seen);
        check_eq("mid_grant", 32'(o_grant_id), 32'h2);
        i_req_valid = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (i_tx_busy) break;
        end
        @(negedge i_clk);
        check_eq("mid_busy", 32'(i_tx_busy), 32'h1);
        check_eq("mid_active", 32'(o_active), 32'h1);
        i_rst = 1'b1;
        #1;
        check_eq("mid_rst_ack", 32'(o_req_ack), 32'h0);
        check_eq("mid_rst_valid", 32'(o_tx_data_valid), 32'h0);
        check_eq("mid_rst_data", 32'(o_tx_data), 32'h0);
        check_eq("mid_rst_grant", 32'(o_grant_id), 32'h0);
        check_eq("mid_rst_active", 32'(o_active), 32'h0);
        check_eq("mid_rst_done", 32'(o_done), 32'h0);
        check_eq("mid_rst_timeout", 32'(o_timeout), 32'h0);
        i_req_valid = 4'b1111;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        wait_issue(seen);
        check_eq("mid_after_issue", 32'(seen), 32'h1);
        check_eq("mid_after_grant", 32'(o_grant_id), 32'h0);
        check_eq("mid_after_ack", 32'(o_req_ack), 32'h1);
        i_req_valid = 4'b0000;
        wait_done(seen, acks, fell);
        check_eq("mid_after_done", 32'(seen), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmit path (shift register, mux and its sequencing FSM) among NUM_REQ byte producers. It grants one requester per frame, presents the latched byte with a one-cycle data-valid pulse, and tracks the transmitter's busy flag to detect frame start and completion. It also times out when the transmitter fails to start. It sits between the producers (register file, debug/log sources) and the UART TX top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, frame payload width; must match the TX datapath
START_TIMEOUT, 8, max cycles in WAIT_START without busy before abort (>=3)
ID_WIDTH (localparam), clog2(NUM_REQ), requester index width

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  asynchronous, active-high reset
i_req_valid  input  NUM_REQ  per-requester byte pending; held until accepted
i_req_data  input  NUM_REQ*DATA_WIDTH  packed bytes, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
o_req_ack  output  NUM_REQ  one-hot, one-cycle pulse: requester's byte consumed
i_tx_busy  input  1  busy flag from the TX sequencer
o_tx_data  output  DATA_WIDTH  byte to TX datapath, registered, stable from ISSUE until return to IDLE
o_tx_data_valid  output  1  one-cycle pulse to TX sequencer
o_grant_id  output  ID_WIDTH  index of current/last granted requester
o_active  output  1  high in every state except IDLE
o_done  output  1  one-cycle pulse when frame completes (busy falls)
o_timeout  output  1  one-cycle pulse when WAIT_START expires

Behaviour:
- Reset (async, i_rst=1): state=IDLE; o_req_ack=0, o_tx_data=0, o_tx_data_valid=0, o_grant_id=0, o_active=0, o_done=0, o_timeout=0; rr pointer=NUM_REQ-1 (requester 0 has first priority); timeout counter=0. Reset mid-frame aborts with no ack, done or timeout pulse.
- All outputs are registered or decoded from registered state only. No combinational path exists from inputs to outputs.
- Winner selection: first k with i_req_valid[k]=1, searching from (ptr+1) mod NUM_REQ upward with wrap-around.
- States:
  - IDLE: if |i_req_valid and !i_tx_busy, then on the clock edge latch winner data into o_tx_data, set o_grant_id=winner and ptr=winner, reset counter, and go to ISSUE. Otherwise stay in IDLE. If i_tx_busy=1, do not grant.
  - ISSUE (exactly 1 cycle): o_tx_data_valid=1, o_req_ack[o_grant_id]=1. Next state is WAIT_START. The requester may drop or replace valid/data in the following cycle.
  - WAIT_START: counter increments each cycle. If i_tx_busy=1, go to WAIT_DONE (busy normally rises 2 cycles after the ISSUE cycle: LOAD then START). If counter reaches START_TIMEOUT-1 with busy still 0, go to IDLE and pulse o_timeout in the next cycle. Busy takes precedence over timeout on the same cycle.
  - WAIT_DONE: stay while i_tx_busy=1. When i_tx_busy=0, go to IDLE and pulse o_done in the first IDLE cycle.
- Grant latency: request seen in IDLE gives ISSUE on the next cycle. Back-to-back frames have a minimum of 1 IDLE cycle between the busy fall and the next ISSUE.
- Requester valid dropping in WAIT_* has no effect. A grant is never revoked after the ISSUE cycle.
- o_tx_data and o_grant_id hold their values in IDLE until the next grant.

Test Plan:
- Single request: i_req_valid=4'b0100, data[2]=8'hA5, TX model with busy rising 2 cycles after valid and lasting 10 cycles. Required: ISSUE 1 cycle after request, o_req_ack=4'b0100 and o_tx_data_valid=1 in the same cycle, o_tx_data=8'hA5, o_done 1 cycle after busy falls, o_grant_id=2.
- Round-robin fairness: all 4 requesting continuously from reset. Required: grant order is 0,1,2,3,0. Each ack coincides with its ISSUE. There is no second ack before o_done.
- Wrap/skip: after grant to 3, only requesters 1 and 2 valid. Required: next grant=1, then 2.
- Timeout: TX model never asserts busy, START_TIMEOUT=8. Required: o_timeout pulses once, state returns to IDLE, ack already given once, next request granted normally.
- Busy at request: i_tx_busy=1 while i_req_valid=4'b0001. Required: no ack and no valid until busy=0, then ISSUE on the following cycle.
- Reset mid-frame: assert i_rst during WAIT_DONE. Required: all outputs immediately 0, o_active=0. After release, requester 0 wins first.
